sample_buffer_reader: RTL and testbench

- Read-side engine for the 2048 x 8 simple dual-port sample RAM.
- The acquisition logic writes the echo samples through port A; this block drives port B.
- It fetches a programmed window of samples, starting at a base address and wrapping at the end of the RAM.
- It presents the samples as a valid/ready byte stream to the display/UART formatter, with full back-pressure support and no dropped or duplicated bytes.

---
 rtl/sonar_pkg.sv | 14 +
 rtl/fifo2_fwft.sv | 63 ++++++
 rtl/sample_buffer_reader.sv | 148 ++++++++++++++
 tb/tb_sample_buffer_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared constants and types for the sonar sample-buffer read path.
package sonar_pkg;

   localparam int unsigned SAMPLE_ADDR_W = 11;
   localparam int unsigned SAMPLE_W      = 8;
   localparam int unsigned SAMPLE_DEPTH  = 2 ** SAMPLE_ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN
   } rd_state_t;

endpackage

// File: rtl/fifo2_fwft.sv
// Two-entry first-word-fall-through FIFO with asynchronous reset.
// A write into an empty FIFO is visible at the head in the same cycle.
module fifo2_fwft
   import sonar_pkg::*;
#(
   parameter int unsigned DW = SAMPLE_W + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_pop,
   output logic [DW-1:0] o_rdata,
   output logic [1:0]    o_count,
   output logic          o_empty,
   output logic          o_full
);

   logic [DW-1:0] r_mem [2];
   logic          r_wptr;
   logic          r_rptr;
   logic [1:0]    r_count;
   logic          w_bypass;
   logic          w_store;
   logic          w_drop;

   // Push and pop of the same word while empty: the word passes straight
   // through and is never stored.
   assign w_bypass = (r_count == 2'd0) && i_push && i_pop;
   assign w_store  = i_push && !w_bypass;
   assign w_drop   = i_pop && (r_count != 2'd0);

   assign o_count  = r_count;
   assign o_full   = (r_count == 2'd2);
   assign o_empty  = (r_count == 2'd0) && !i_push;
   assign o_rdata  = (r_count != 2'd0) ? r_mem[r_rptr] : (i_push ? i_wdata : '0);

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_store) begin
            r_mem[r_wptr] <= i_wdata;
            r_wptr        <= ~r_wptr;
         end
         if (w_drop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_store, w_drop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/sample_buffer_reader.sv
// Read-side engine for the sample RAM: fetches a window of samples through
// RAM port B and streams them out as valid/ready bytes with back-pressure.
module sample_buffer_reader
   import sonar_pkg::*;
#(
   parameter int unsigned ADDR_W = SAMPLE_ADDR_W,
   parameter int unsigned DATA_W = SAMPLE_W,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic              ram_ce,
   output logic              ram_oce,
   output logic [ADDR_W-1:0] ram_adb,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last
);

   // Words outstanding (stored + in flight) may never exceed the FIFO depth.
   localparam logic [2:0] CREDIT_LIMIT = 3'(RD_LAT + 1);

   rd_state_t         r_state;
   rd_state_t         w_state_nxt;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W:0]   r_issue_cnt;
   logic [ADDR_W:0]   r_beat_cnt;
   logic              r_inflight;
   logic              r_inflight_last;
   logic              r_zero_done;
   logic              w_start_ok;
   logic              w_accept;
   logic              w_zero_start;
   logic              w_credit_ok;
   logic              w_issue;
   logic              w_final_issue;
   logic              w_pop;
   logic [1:0]        w_fifo_count;
   logic              w_fifo_empty;
   logic              w_fifo_full;
   logic [DATA_W:0]   w_fifo_head;

   // A zero-length request completes with a done pulse while still in IDLE;
   // a start coinciding with that pulse is ignored like any start during done.
   assign w_start_ok    = (r_state == IDLE) && start && !r_zero_done;
   assign w_accept      = w_start_ok && (length != '0);
   assign w_zero_start  = w_start_ok && (length == '0);
   assign w_credit_ok   = (({1'b0, w_fifo_count} + {2'b00, r_inflight}) < CREDIT_LIMIT);
   assign w_issue       = (r_state == READ) && (r_issue_cnt != '0) && w_credit_ok && !w_fifo_full;
   assign w_final_issue = w_issue && (r_issue_cnt == (ADDR_W+1)'(1));
   assign w_pop         = m_valid && m_ready;

   assign ram_oce = 1'b1;
   assign ram_adb = r_rd_addr;
   assign m_valid = !w_fifo_empty;
   assign m_data  = w_fifo_head[DATA_W-1:0];
   assign m_last  = w_fifo_head[DATA_W];

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and control outputs; done is raised in DRAIN as soon as the
   // last beat has gone, so busy drops in that same cycle.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = r_zero_done;
      ram_ce      = w_issue;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = READ;
            end
         end
         READ: begin
            busy = 1'b1;
            if (w_final_issue) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (r_beat_cnt == '0) begin
               done        = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               busy = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Address, issue/beat counters and the one-deep in-flight tracker.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_addr       <= '0;
         r_issue_cnt     <= '0;
         r_beat_cnt      <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_zero_done     <= 1'b0;
      end else begin
         r_zero_done     <= w_zero_start;
         r_inflight      <= w_issue;
         r_inflight_last <= w_final_issue;
         if (w_accept) begin
            r_rd_addr   <= base_addr;
            r_issue_cnt <= length;
         end else if (w_issue) begin
            r_rd_addr   <= r_rd_addr + ADDR_W'(1);
            r_issue_cnt <= r_issue_cnt - (ADDR_W+1)'(1);
         end
         if (w_accept) begin
            r_beat_cnt <= length;
         end else if (w_pop) begin
            r_beat_cnt <= r_beat_cnt - (ADDR_W+1)'(1);
         end
      end
   end

   fifo2_fwft #(
      .DW(DATA_W + 1)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (r_inflight),
      .i_wdata ({r_inflight_last, ram_dout}),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_head),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

endmodule

// File: tb/tb_sample_buffer_reader.sv
// Directed testbench for sample_buffer_reader with a behavioural 2048 x 8 RAM.
module tb_sample_buffer_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] base_addr;
   logic [11:0] length;
   logic        busy;
   logic        done;
   logic        ram_ce;
   logic        ram_oce;
   logic [10:0] ram_adb;
   logic [7:0]  ram_dout;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;

   logic [7:0]  mem [2048];
   int          n_pass = 0;
   int          n_fail = 0;
   int          n_total = 0;

   int          first_bt, last_hs, done_cyc, n_iss, n_bt, n_lst;

   sample_buffer_reader #(
      .ADDR_W(11),
      .DATA_W(8),
      .RD_LAT(1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .ram_ce    (ram_ce),
      .ram_oce   (ram_oce),
      .ram_adb   (ram_adb),
      .ram_dout  (ram_dout),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last)
   );

   always #5 clk = ~clk;

   // Port-B read model: one clock of latency, no output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_dout <= '0;
      end else if (ram_ce) begin
         ram_dout <= mem[ram_adb];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},    busy,    0);
      chk({tag, "_done"},    done,    0);
      chk({tag, "_ram_ce"},  ram_ce,  0);
      chk({tag, "_ram_adb"}, ram_adb, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_last"},  m_last,  0);
      chk({tag, "_m_data"},  m_data,  0);
   endtask

   task automatic quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_busy"},    busy,    0);
         chk({tag, "_done"},    done,    0);
         chk({tag, "_ram_ce"},  ram_ce,  0);
         chk({tag, "_m_valid"}, m_valid, 0);
         @(negedge clk);
      end
   endtask

   // Starts a burst at the current negedge (cycle 0) and follows it cycle by
   // cycle. pat 0: ready always high; pat 1: ready 1,0,0 repeating from the
   // first possible beat. poke: cycle at which a stray start is pulsed.
   // abort_at: return right after this many beats (0 = run to done).
   task automatic burst(input logic [10:0] b, input logic [11:0] len, input int pat,
                        input int poke, input int abort_at,
                        output int o_first, output int o_last_hs, output int o_done,
                        output int o_iss, output int o_bt, output int o_lst);
      logic [10:0] a_exp;
      logic        prev_stall;
      logic [7:0]  prev_d;
      logic        got_done;
      int          budget;
      o_first = -1; o_last_hs = -1; o_done = -1;
      o_iss = 0; o_bt = 0; o_lst = 0;
      prev_stall = 1'b0; prev_d = '0; got_done = 1'b0;
      budget = int'(len) * 4 + 20;
      start = 1'b1; base_addr = b; length = len; m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k < budget; k++) begin
         m_ready = (pat == 0) ? 1'b1 : ((k + 1) % 3 == 0);
         if (k == poke) begin
            start = 1'b1; base_addr = b ^ 11'h400; length = 12'd3;
         end else begin
            start = 1'b0;
         end
         if (k == 1) chk("busy_c1", busy, (len != 0));
         if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_d);
         end
         if (ram_ce) begin
            a_exp = b + 11'(o_iss);
            chk("issue_addr", ram_adb, a_exp);
            chk("credit", ((o_iss - o_bt) < 2), 1);
            o_iss++;
         end
         if (m_valid && m_ready) begin
            a_exp = b + 11'(o_bt);
            chk("beat_data", m_data, a_exp[7:0]);
            chk("beat_last", m_last, (o_bt == int'(len) - 1));
            if (m_last) o_lst++;
            if (o_first < 0) o_first = k;
            o_last_hs = k;
            o_bt++;
         end
         prev_stall = m_valid && !m_ready;
         prev_d     = m_data;
         if (done) begin
            o_done   = k;
            got_done = 1'b1;
            chk("busy_at_done", busy, 0);
            break;
         end
         if (abort_at > 0 && o_bt == abort_at) break;
         @(negedge clk);
      end
      if (abort_at == 0) begin
         chk("done_seen", got_done, 1);
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
      for (int i = 0; i < 2048; i++) begin
         mem[i] = 8'(i);
      end
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      chk("rst_ram_oce", ram_oce, 1);
      reset = 1'b0;
      @(negedge clk);

      // Basic burst; a start in the done cycle (cycle 6) must be ignored.
      burst(11'h010, 12'd4, 0, 6, 0, first_bt, last_hs, done_cyc, n_iss, n_bt, n_lst);
      chk("basic_first", first_bt, 2);
      chk("basic_last_hs", last_hs, 5);
      chk("basic_done", done_cyc, 6);
      chk("basic_done_after_hs", done_cyc, last_hs + 1);
      chk("basic_beats", n_bt, 4);
      chk("basic_issues", n_iss, 4);
      chk("basic_lastflags", n_lst, 1);
      quiet("after_done_start", 4);

      // Wrap at the top of the RAM.
      burst(11'h7FE, 12'd4, 0, -1, 0, first_bt, last_hs, done_cyc, n_iss, n_bt, n_lst);
      chk("wrap_beats", n_bt, 4);
      chk("wrap_issues", n_iss, 4);
      chk("wrap_done", done_cyc, 6);

      // Back-pressure with a stray start mid-burst.
      burst(11'h050, 12'd8, 1, 4, 0, first_bt, last_hs, done_cyc, n_iss, n_bt, n_lst);
      chk("bp_beats", n_bt, 8);
      chk("bp_issues", n_iss, 8);
      chk("bp_lastflags", n_lst, 1);
      chk("bp_done_after_hs", done_cyc, last_hs + 1);
      quiet("after_busy_start", 4);

      // Zero length.
      burst(11'h020, 12'd0, 0, -1, 0, first_bt, last_hs, done_cyc, n_iss, n_bt, n_lst);
      chk("zero_done", done_cyc, 1);
      chk("zero_issues", n_iss, 0);
      chk("zero_beats", n_bt, 0);
      quiet("after_zero", 2);

      // Full RAM from 0x123; last beat carries address 0x122.
      burst(11'h123, 12'd2048, 0, -1, 0, first_bt, last_hs, done_cyc, n_iss, n_bt, n_lst);
      chk("full_beats", n_bt, 2048);
      chk("full_issues", n_iss, 2048);
      chk("full_lastflags", n_lst, 1);
      chk("full_done", done_cyc, 2050);

      // Reset after three beats.
      burst(11'h200, 12'd8, 0, -1, 3, first_bt, last_hs, done_cyc, n_iss, n_bt, n_lst);
      chk("abort_beats", n_bt, 3);
      reset = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      quiet("after_reset", 4);

      // Fresh burst after reset.
      burst(11'h010, 12'd4, 0, -1, 0, first_bt, last_hs, done_cyc, n_iss, n_bt, n_lst);
      chk("post_first", first_bt, 2);
      chk("post_done", done_cyc, 6);
      chk("post_beats", n_bt, 4);
      chk("post_lastflags", n_lst, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
